// File: rtl/spatz_spm_partition_ctrl.sv
// Scratchpad/cache partition controller.
// A resize request stalls the cache and waits for it to drain. It then writes
// back and invalidates every line index between the old and new SPM size, waits
// for those flushes to settle, and only then commits the new SPM size to the
// SRAM wrapper.
module spatz_spm_partition_ctrl #(
    parameter int unsigned BankAddrWidth = 8,
    parameter int unsigned ResetSpmSize  = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [BankAddrWidth-1:0] cfg_size_i,
    output logic [BankAddrWidth-1:0] spm_size_o,
    output logic                     cache_stall_o,
    input  logic                     cache_idle_i,
    output logic                     flush_valid_o,
    input  logic                     flush_ready_i,
    output logic [BankAddrWidth-1:0] flush_addr_o,
    output logic                     busy_o
);

    // One extra bit so a sweep ending at the top line index compares without wrapping.
    localparam int unsigned CntWidth = BankAddrWidth + 1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH,
        FWAIT,
        COMMIT
    } state_e;

    state_e                     state_q, state_d;
    logic [CntWidth-1:0]        cnt_q, cnt_d;
    logic [CntWidth-1:0]        hi_q, hi_d;
    logic [BankAddrWidth-1:0]   new_q, new_d;
    logic [BankAddrWidth-1:0]   size_q, size_d;

    logic                       cfg_ready_q, cfg_ready_d;
    logic                       busy_q, busy_d;
    logic                       stall_q, stall_d;
    logic                       flush_valid_q, flush_valid_d;
    logic [BankAddrWidth-1:0]   flush_addr_q, flush_addr_d;

    // Next-state logic, sweep bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        new_d   = new_q;
        size_d  = size_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid_i && cfg_ready_q) begin
                    new_d = cfg_size_i;
                    // The sweep always runs upward from the smaller size to the larger one.
                    if (cfg_size_i < size_q) begin
                        cnt_d = CntWidth'(cfg_size_i);
                        hi_d  = CntWidth'(size_q);
                    end else begin
                        cnt_d = CntWidth'(size_q);
                        hi_d  = CntWidth'(cfg_size_i);
                    end
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cache_idle_i) begin
                    state_d = (cnt_q < hi_q) ? FLUSH : COMMIT;
                end
            end
            FLUSH: begin
                if (flush_ready_i) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_d == hi_q) begin
                        state_d = FWAIT;
                    end
                end
            end
            FWAIT: begin
                if (cache_idle_i) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                size_d  = new_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cfg_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        stall_d       = (state_d != IDLE);
        flush_valid_d = (state_d == FLUSH);
        flush_addr_d  = flush_valid_d ? cnt_d[BankAddrWidth-1:0] : '0;
    end

    // State, sweep and output registers; reset abandons any sweep in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            new_q         <= '0;
            size_q        <= BankAddrWidth'(ResetSpmSize);
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            stall_q       <= 1'b0;
            flush_valid_q <= 1'b0;
            flush_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            new_q         <= new_d;
            size_q        <= size_d;
            cfg_ready_q   <= cfg_ready_d;
            busy_q        <= busy_d;
            stall_q       <= stall_d;
            flush_valid_q <= flush_valid_d;
            flush_addr_q  <= flush_addr_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign busy_o        = busy_q;
    assign cache_stall_o = stall_q;
    assign flush_valid_o = flush_valid_q;
    assign flush_addr_o  = flush_addr_q;
    assign spm_size_o    = size_q;

endmodule
